// File: rtl/ddr_mem_responder.sv
// Simple DDR-style memory responder: single-word writes, burst reads with a
// programmable idle latency, host preload port and a sticky address-error flag.
module ddr_mem_responder #(
  parameter int          MEM_WORDS    = 65536,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] BAD_DATA     = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ddr_read_req,
  input  logic [31:0] ddr_read_addr,
  input  logic [7:0]  ddr_read_len,
  output logic        ddr_read_grant,
  output logic [31:0] ddr_read_data,
  output logic        ddr_read_valid,
  input  logic        ddr_write_req,
  input  logic [31:0] ddr_write_addr,
  input  logic [31:0] ddr_write_data,
  output logic        ddr_write_grant,
  input  logic        init_we,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_data,
  output logic        busy,
  output logic        addr_err
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, RD_GRANT, RD_WAIT, RD_DATA, WR_GRANT} state_t;

  state_t      state, state_nxt;
  logic [29:0] rd_ptr;
  logic [29:0] wr_idx;
  logic [31:0] wr_data;
  logic [7:0]  len_q;
  logic [7:0]  beat_cnt;
  logic [3:0]  wait_cnt;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] ram_data_p1;
  logic        ram_oob_p1;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{ddr_read_addr[1:0], ddr_write_addr[1:0], init_addr[1:0]};

  function automatic logic out_of_range(input logic [29:0] idx);
    return {2'b00, idx} >= 32'(MEM_WORDS);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ddr_write_req)     state_nxt = WR_GRANT;
        else if (ddr_read_req) state_nxt = RD_GRANT;
      end
      RD_GRANT: begin
        if (len_q == 8'd0)         state_nxt = IDLE;
        else if (READ_LATENCY > 0) state_nxt = RD_WAIT;
        else                       state_nxt = RD_DATA;
      end
      RD_WAIT:  if (wait_cnt == 4'd0) state_nxt = RD_DATA;
      RD_DATA:  if (beat_cnt == len_q - 8'd1) state_nxt = IDLE;
      WR_GRANT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign ddr_read_grant  = (state == RD_GRANT);
  assign ddr_write_grant = (state == WR_GRANT);
  assign ddr_read_valid  = (state == RD_DATA);
  assign busy            = (state != IDLE);
  assign ddr_read_data   = !ddr_read_valid ? 32'd0 : (ram_oob_p1 ? BAD_DATA : ram_data_p1);

  // rd_ptr runs one word ahead of the beat on the bus so the RAM register
  // already holds each beat's word when RD_DATA presents it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_idx   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      addr_err <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (ddr_write_req) begin
          wr_idx <= ddr_write_addr[31:2];
        end else if (ddr_read_req) begin
          rd_ptr   <= ddr_read_addr[31:2];
          len_q    <= ddr_read_len;
          beat_cnt <= '0;
        end
      end
      if (state == RD_GRANT)
        wait_cnt <= 4'(READ_LATENCY - 1);
      else if (state == RD_WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (state_nxt == RD_DATA) rd_ptr <= rd_ptr + 30'd1;
      if (state == RD_DATA)     beat_cnt <= beat_cnt + 8'd1;
      if ((state == WR_GRANT && out_of_range(wr_idx)) ||
          (state == RD_DATA && ram_oob_p1) ||
          (init_we && out_of_range(init_addr[31:2])))
        addr_err <= 1'b1;
    end
  end

  // Storage: no reset; init write is ordered last so it wins a collision.
  always_ff @(posedge clk) begin
    if (state == IDLE && ddr_write_req) wr_data <= ddr_write_data;
    if (state == WR_GRANT && !out_of_range(wr_idx))
      mem[wr_idx[AW-1:0]] <= wr_data;
    if (init_we && !out_of_range(init_addr[31:2]))
      mem[init_addr[AW+1:2]] <= init_data;
    ram_data_p1 <= mem[rd_ptr[AW-1:0]];
    ram_oob_p1  <= out_of_range(rd_ptr);
  end
endmodule

// File: tb/tb_ddr_mem_responder.sv
// Scoreboard bench for ddr_mem_responder: stimulus pushes expected beats,
// a negedge monitor pops and compares every valid beat.
module tb_ddr_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ddr_read_req = 1'b0;
  logic [31:0] ddr_read_addr = '0;
  logic [7:0]  ddr_read_len = '0;
  logic        ddr_read_grant;
  logic [31:0] ddr_read_data;
  logic        ddr_read_valid;
  logic        ddr_write_req = 1'b0;
  logic [31:0] ddr_write_addr = '0;
  logic [31:0] ddr_write_data = '0;
  logic        ddr_write_grant;
  logic        init_we = 1'b0;
  logic [31:0] init_addr = '0;
  logic [31:0] init_data = '0;
  logic        busy;
  logic        addr_err;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [16];

  ddr_mem_responder #(.MEM_WORDS(16), .READ_LATENCY(2), .BAD_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .ddr_read_req(ddr_read_req), .ddr_read_addr(ddr_read_addr), .ddr_read_len(ddr_read_len),
    .ddr_read_grant(ddr_read_grant), .ddr_read_data(ddr_read_data), .ddr_read_valid(ddr_read_valid),
    .ddr_write_req(ddr_write_req), .ddr_write_addr(ddr_write_addr), .ddr_write_data(ddr_write_data),
    .ddr_write_grant(ddr_write_grant),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid beat must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (ddr_read_valid) begin
        if (exp_q.size() == 0) check("unexpected_beat", ddr_read_data, 32'hxxxx_xxxx);
        else check("beat_data", ddr_read_data, exp_q.pop_front());
      end else if (rst_n) begin
        check("idle_data_zero", ddr_read_data, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_init(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    init_we = 1'b1; init_addr = addr; init_data = data;
    @(posedge clk); #1;
    init_we = 1'b0;
    if (addr[31:2] < 16) model[addr[5:2]] = data;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len);
    int lat;
    bit got;
    @(posedge clk); #1;
    ddr_read_addr = addr; ddr_read_len = len; ddr_read_req = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ddr_read_grant) got = 1'b1;
    end
    ddr_read_req = 1'b0;
    check("read_grant_latency", 32'(lat), 32'd2);
    @(negedge clk);
    check("read_grant_width", {31'd0, ddr_read_grant}, 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    int lat;
    bit got;
    @(posedge clk); #1;
    ddr_write_addr = addr; ddr_write_data = data; ddr_write_req = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ddr_write_grant) got = 1'b1;
    end
    ddr_write_req = 1'b0;
    if (addr[31:2] < 16) model[addr[5:2]] = data;
    check("write_grant_latency", 32'(lat), 32'd2);
    @(negedge clk);
    check("write_grant_width", {31'd0, ddr_write_grant}, 32'd0);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int nv;
    int wl;
    int rl;
    bit got;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, ddr_read_valid}, 32'd0);
    check("rst_data", ddr_read_data, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    check("rst_grants", {30'd0, ddr_read_grant, ddr_write_grant}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) do_init(32'(i * 4), 32'h10 + 32'(i));
    for (int i = 4; i < 16; i++) do_init(32'(i * 4), 32'h1000 + 32'(i));

    // Burst of 4 with latency 2: beats three negedges after the grant cycle
    exp_q.push_back(32'h10); exp_q.push_back(32'h11);
    exp_q.push_back(32'h12); exp_q.push_back(32'h13);
    do_read(32'h0, 8'd4);
    check("lat_cycle_n2", {31'd0, ddr_read_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle_n3", {31'd0, ddr_read_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("beat_valid_run", {31'd0, ddr_read_valid}, 32'd1);
    end
    @(negedge clk);
    check("after_last_beat", {31'd0, ddr_read_valid}, 32'd0);
    wait_idle();

    // Write and read together: write wins, read follows and sees new data
    exp_q.push_back(32'h0000_ABCD);
    @(posedge clk); #1;
    ddr_write_addr = 32'h8; ddr_write_data = 32'h0000_ABCD; ddr_write_req = 1'b1;
    ddr_read_addr = 32'h8; ddr_read_len = 8'd1; ddr_read_req = 1'b1;
    wl = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); wl++;
      if (ddr_write_grant) got = 1'b1;
    end
    check("prio_write_latency", 32'(wl), 32'd2);
    check("prio_no_read_grant", {31'd0, ddr_read_grant}, 32'd0);
    ddr_write_req = 1'b0;
    model[2] = 32'h0000_ABCD;
    rl = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); rl++;
      if (ddr_read_grant) got = 1'b1;
    end
    ddr_read_req = 1'b0;
    check("prio_read_after_write", 32'(rl), 32'd2);
    wait_idle();

    // Zero-length read: grant only, idle two cycles after the request edge
    do_read(32'h4, 8'd0);
    check("len0_busy_low", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("len0_no_beats", {31'd0, ddr_read_valid}, 32'd0);
    check("no_err_yet", {31'd0, addr_err}, 32'd0);

    // Burst running past the end of a 16-word store
    exp_q.push_back(32'h0000_100E); exp_q.push_back(32'h0000_100F);
    exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hDEAD_BEEF);
    do_read(32'h38, 8'd4);
    wait_idle();
    check("oob_addr_err", {31'd0, addr_err}, 32'd1);

    // Back-to-back held requests
    do_write(32'h10, 32'h5555_0001);
    do_write(32'h14, 32'h5555_0002);
    exp_q.push_back(model[4]); exp_q.push_back(model[5]); exp_q.push_back(model[6]);
    do_read(32'h10, 8'd3);
    wait_idle();
    check("addr_err_sticky", {31'd0, addr_err}, 32'd1);

    // Reset during beat 2 of an 8-beat burst
    for (int i = 0; i < 8; i++) exp_q.push_back(model[i]);
    do_read(32'h0, 8'd8);
    nv = 0;
    for (int i = 0; i < 20 && nv < 2; i++) begin
      @(negedge clk);
      if (ddr_read_valid) nv++;
    end
    check("midburst_beats_seen", 32'(nv), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, ddr_read_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_data", ddr_read_data, 32'd0);
    check("abort_addr_err", {31'd0, addr_err}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("abort_no_beats", {31'd0, ddr_read_valid}, 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(32'h11);
    do_read(32'h4, 8'd1);
    wait_idle();
    check("post_reset_err_clear", {31'd0, addr_err}, 32'd0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
